// File: rtl/accum_rate_decoder.sv
// Recovers the per-cycle increment of a free-running 2*DATA_W accumulator from its upper half.
// Latency start->est_valid = 2^(DATA_W+AVG_LOG2)+1 cycles; est held stable until est_ready.
module accum_rate_decoder #(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    output logic [DATA_W-1:0] est,
    output logic              est_valid,
    input  logic              est_ready,
    output logic              busy,
    output logic              locked
);
    localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] est_q, est_d;
    logic              est_valid_q, est_valid_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              have_prev_q, have_prev_d;

    logic [DATA_W-1:0] delta;
    logic [SUM_W-1:0]  sum_nxt;
    logic              hs;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        sum_d       = sum_q;
        est_d       = est_q;
        est_valid_d = est_valid_q;
        locked_d    = locked_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        // Modular difference: a wrapped upper half still yields the true advance.
        delta       = acc_hi - base_q;
        sum_nxt     = sum_q + SUM_W'(delta);
        hs          = est_valid_q & est_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = acc_hi;
                    cnt_d   = '0;
                    win_d   = '0;
                    sum_d   = '0;
                    state_d = S_MEAS;
                end
            end
            S_MEAS: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DATA_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        base_d = acc_hi;
                        sum_d  = sum_nxt;
                        if (win_q == WIN_LAST) begin
                            est_d       = sum_nxt[SUM_W-1 -: DATA_W];
                            est_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    est_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (hs) begin
                    est_valid_d = 1'b0;
                    locked_d    = have_prev_q && (est_q == prev_q);
                    prev_d      = est_q;
                    have_prev_d = 1'b1;
                    if (cont) begin
                        base_d  = acc_hi;
                        cnt_d   = '0;
                        win_d   = '0;
                        sum_d   = '0;
                        state_d = S_MEAS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_MEAS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            sum_q       <= '0;
            est_q       <= '0;
            est_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            est_q       <= est_d;
            est_valid_q <= est_valid_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign est       = est_q;
    assign est_valid = est_valid_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
endmodule

// File: tb/tb_accum_rate_decoder.sv
// Bench for accum_rate_decoder: accumulator model drives acc_hi, scoreboard checks every delivered estimate.
module tb_accum_rate_decoder;
    logic       clk = 1'b0;
    logic       rst, start, cont, abort, est_ready;
    logic [7:0] acc_hi, est;
    logic       est_valid, busy, locked;

    logic [15:0] acc;
    logic [15:0] acc_init;
    logic [7:0]  inc;
    logic        acc_load;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] est;
        logic       lk;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] prev_est;
    logic       have_prev;

    always #5 clk = ~clk;

    always @(posedge clk) acc <= acc_load ? acc_init : acc + {8'd0, inc};
    assign acc_hi = acc[15:8];

    accum_rate_decoder #(.DATA_W(8), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .acc_hi(acc_hi), .start(start), .cont(cont), .abort(abort),
        .est(est), .est_valid(est_valid), .est_ready(est_ready), .busy(busy), .locked(locked)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Expected locked follows from the sequence of delivered estimates since reset.
    task automatic expect_est(input logic [7:0] e);
        exp_t x;
        x.est = e;
        x.lk  = have_prev && (e == prev_est);
        exp_q.push_back(x);
        prev_est  = e;
        have_prev = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!est_valid && edges < 3000) begin
            tick();
            edges++;
        end
        if (!est_valid) check("est_valid_timeout", 0, 1);
    endtask

    task automatic run_meas(input logic [7:0] e);
        int n;
        expect_est(e);
        do_start();
        wait_valid(n);
        tick();
    endtask

    // Monitor: pops the scoreboard on every accepted handshake, then checks locked a cycle later.
    logic lk_pend = 1'b0;
    logic lk_exp  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (lk_pend) begin
            lk_pend = 1'b0;
            check("locked", int'(locked), int'(lk_exp));
        end
        if (!rst && !abort && est_valid && est_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_est", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("est", int'(est), int'(e.est));
                lk_exp  = e.lk;
                lk_pend = 1'b1;
            end
        end
    end

    initial begin
        int n;
        int bad;
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; est_ready = 1'b1;
        acc_load = 1'b1; acc_init = 16'h0000; inc = 8'd3;
        have_prev = 1'b0; prev_est = 8'd0;
        repeat (3) tick();
        check("rst_est", int'(est), 0);
        check("rst_est_valid", int'(est_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        rst = 1'b0;
        acc_load = 1'b0;

        // inc=3 from acc=0: latency counted from the start cycle is 1025
        expect_est(8'd3);
        do_start();
        check("busy_after_start", int'(busy), 1);
        wait_valid(n);
        check("latency", n + 1, 1025);
        check("busy_in_done", int'(busy), 0);
        tick();

        inc = 8'd0;
        run_meas(8'd0);
        acc_load = 1'b1; acc_init = 16'hFF00; inc = 8'd255;
        tick();
        acc_load = 1'b0;
        run_meas(8'd255);

        // deltas 4,4,8,8 -> 6
        inc = 8'd4;
        expect_est(8'd6);
        do_start();
        repeat (511) tick();
        inc = 8'd8;
        wait_valid(n);
        tick();

        // deltas 4,4,4,5 -> 17>>2 = 4
        inc = 8'd4;
        expect_est(8'd4);
        do_start();
        repeat (767) tick();
        inc = 8'd5;
        wait_valid(n);
        tick();

        // backpressure hold, then cont handshake and lock tracking
        inc = 8'd3;
        est_ready = 1'b0;
        expect_est(8'd3);
        do_start();
        wait_valid(n);
        bad = 0;
        repeat (50) begin
            tick();
            if (!est_valid || est != 8'd3) bad++;
        end
        check("hold_stable_errors", bad, 0);
        expect_est(8'd3);
        est_ready = 1'b1;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        check("busy_after_cont", int'(busy), 1);
        wait_valid(n);
        check("cont_latency", n + 1, 1025);
        tick();
        inc = 8'd7;
        run_meas(8'd7);

        // abort at cnt=100 of window 2
        do_start();
        repeat (356) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_est_valid", int'(est_valid), 0);
        bad = 0;
        repeat (1100) begin
            tick();
            if (est_valid || busy) bad++;
        end
        check("abort_stays_idle", bad, 0);
        run_meas(8'd7);

        // start while busy is ignored
        expect_est(8'd7);
        do_start();
        repeat (299) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        check("latency_restart_ignored", n + 301, 1025);
        tick();

        // reset mid-MEAS
        do_start();
        repeat (200) tick();
        rst = 1'b1;
        tick();
        check("rst_meas_est", int'(est), 0);
        check("rst_meas_busy", int'(busy), 0);
        check("rst_meas_locked", int'(locked), 0);
        check("rst_meas_est_valid", int'(est_valid), 0);
        rst = 1'b0;
        have_prev = 1'b0;

        // reset during DONE with est_ready high: estimate is never delivered
        run_meas(8'd7);
        run_meas(8'd7);
        do_start();
        wait_valid(n);
        rst = 1'b1;
        tick();
        check("rst_done_est", int'(est), 0);
        check("rst_done_est_valid", int'(est_valid), 0);
        check("rst_done_busy", int'(busy), 0);
        check("rst_done_locked", int'(locked), 0);
        rst = 1'b0;
        have_prev = 1'b0;
        run_meas(8'd7);

        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
